sos_ctrl_module: RTL



---
 rtl/sos_ctrl_module.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sos_ctrl_module.sv
// sos_ctrl_module
// Sequences the S, O and S letter generators to form one SOS frame. It inserts
// millisecond-timed letter and word gaps, repeats frames while enabled, muxes
// the active generator's LED pin onto one output, and flags a generator that
// never completes.
//
// Ports
//   CLK, RSTn          system clock, asynchronous active-low reset
//   En_Sig             run request (level)
//   S_Done_Sig         one-cycle completion pulse from the S generator
//   O_Done_Sig         one-cycle completion pulse from the O generator
//   S_Pin_In           S generator LED pin (active-low)
//   O_Pin_In           O generator LED pin (active-low)
//   S_Start_Sig        level start to the S generator
//   O_Start_Sig        level start to the O generator
//   Pin_Out            muxed LED pin (active-low, combinational)
//   Busy_Sig           high in any state except IDLE
//   Frame_Done_Sig     one-cycle pulse per completed frame
//   Letter_Idx         0 idle/gap, 1 first S, 2 O, 3 second S
//   Err_Sig            sticky generator-timeout flag
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for En_Sig
// RUN_S1    | first S letter running, waiting for S_Done_Sig
// GAP1      | letter gap before the O
// RUN_O     | O letter running, waiting for O_Done_Sig
// GAP2      | letter gap before the second S
// RUN_S2    | second S letter running, waiting for S_Done_Sig
// FRAME_END | one cycle: count the frame, pulse Frame_Done_Sig
// WORD_GAP  | gap between frames; En_Sig low aborts to IDLE
module sos_ctrl_module #(
  parameter logic [15:0] T1MS          = 16'd49_999,
  parameter logic [9:0]  LETTER_GAP_MS = 10'd150,
  parameter logic [9:0]  WORD_GAP_MS   = 10'd350,
  parameter logic [7:0]  N_FRAMES      = 8'd0,
  parameter logic [9:0]  TIMEOUT_MS    = 10'd1000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       En_Sig,
  input  logic       S_Done_Sig,
  input  logic       O_Done_Sig,
  input  logic       S_Pin_In,
  input  logic       O_Pin_In,
  output logic       S_Start_Sig,
  output logic       O_Start_Sig,
  output logic       Pin_Out,
  output logic       Busy_Sig,
  output logic       Frame_Done_Sig,
  output logic [1:0] Letter_Idx,
  output logic       Err_Sig
);

  typedef enum logic [2:0] {
    IDLE, RUN_S1, GAP1, RUN_O, GAP2, RUN_S2, FRAME_END, WORD_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pre_cnt;
  logic [9:0]  ms_cnt;
  logic [7:0]  frame_cnt, frame_cnt_d;
  logic        s_start_d, o_start_d, busy_d, frame_done_d, err_d;
  logic [1:0]  letter_idx_d;
  logic        ms_tick, gap_done, word_done, to_hit, more_frames, timer_run, in_run;

  // A delay of N ms ends on the edge where the Nth ms completes, so a gap
  // lasts exactly N*(T1MS+1) cycles from its entry edge.
  assign ms_tick     = (pre_cnt == T1MS);
  assign gap_done    = ms_tick && (ms_cnt == LETTER_GAP_MS - 10'd1);
  assign word_done   = ms_tick && (ms_cnt == WORD_GAP_MS - 10'd1);
  assign to_hit      = ms_tick && (ms_cnt == TIMEOUT_MS - 10'd1);
  assign more_frames = (N_FRAMES == 8'd0) || (frame_cnt < N_FRAMES);
  assign in_run      = (state == RUN_S1) || (state == RUN_O) || (state == RUN_S2);
  assign timer_run   = in_run || (state == GAP1) || (state == GAP2) || (state == WORD_GAP);

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a Done pulse takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (En_Sig) state_nxt = RUN_S1;
      RUN_S1:    if (S_Done_Sig) state_nxt = GAP1;
                 else if (to_hit) state_nxt = IDLE;
      GAP1:      if (gap_done) state_nxt = RUN_O;
      RUN_O:     if (O_Done_Sig) state_nxt = GAP2;
                 else if (to_hit) state_nxt = IDLE;
      GAP2:      if (gap_done) state_nxt = RUN_S2;
      RUN_S2:    if (S_Done_Sig) state_nxt = FRAME_END;
                 else if (to_hit) state_nxt = IDLE;
      FRAME_END: state_nxt = (En_Sig && more_frames) ? WORD_GAP : IDLE;
      WORD_GAP:  if (!En_Sig) state_nxt = IDLE;
                 else if (word_done) state_nxt = RUN_S1;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic: outputs are decoded from the next state and registered, so
  // they change on the same edge as the state register.
  always_comb begin
    s_start_d    = (state_nxt == RUN_S1) || (state_nxt == RUN_S2);
    o_start_d    = (state_nxt == RUN_O);
    busy_d       = (state_nxt != IDLE);
    frame_done_d = (state_nxt == FRAME_END);
    case (state_nxt)
      RUN_S1:  letter_idx_d = 2'd1;
      RUN_O:   letter_idx_d = 2'd2;
      RUN_S2:  letter_idx_d = 2'd3;
      default: letter_idx_d = 2'd0;
    endcase
    err_d       = Err_Sig;
    frame_cnt_d = frame_cnt;
    if (state == IDLE && state_nxt == RUN_S1) begin
      err_d       = 1'b0;
      frame_cnt_d = 8'd0;
    end
    if (in_run && state_nxt == IDLE) err_d = 1'b1;
    if (state_nxt == FRAME_END && state != FRAME_END && frame_cnt != 8'hFF)
      frame_cnt_d = frame_cnt + 8'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      S_Start_Sig    <= 1'b0;
      O_Start_Sig    <= 1'b0;
      Busy_Sig       <= 1'b0;
      Frame_Done_Sig <= 1'b0;
      Letter_Idx     <= 2'd0;
      Err_Sig        <= 1'b0;
      frame_cnt      <= 8'd0;
    end else begin
      S_Start_Sig    <= s_start_d;
      O_Start_Sig    <= o_start_d;
      Busy_Sig       <= busy_d;
      Frame_Done_Sig <= frame_done_d;
      Letter_Idx     <= letter_idx_d;
      Err_Sig        <= err_d;
      frame_cnt      <= frame_cnt_d;
    end
  end

  // Prescaler and ms counter restart on every state change.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre_cnt <= 16'd0;
      ms_cnt  <= 10'd0;
    end else if (state_nxt != state) begin
      pre_cnt <= 16'd0;
      ms_cnt  <= 10'd0;
    end else if (timer_run) begin
      if (ms_tick) begin
        pre_cnt <= 16'd0;
        ms_cnt  <= ms_cnt + 10'd1;
      end else begin
        pre_cnt <= pre_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    case (Letter_Idx)
      2'd1, 2'd3: Pin_Out = S_Pin_In;
      2'd2:       Pin_Out = O_Pin_In;
      default:    Pin_Out = 1'b1;
    endcase
  end

endmodule
